// File: rtl/vga_regs_pkg.sv
// Shared types for the VGA sprite register path: register indices,
// the queued update record and the commit FSM states.
package vga_regs_pkg;

  localparam logic [2:0] REG_PLAYER_Y  = 3'd0;
  localparam logic [2:0] REG_X_SHIFT   = 3'd1;
  localparam logic [2:0] REG_BG_R      = 3'd2;
  localparam logic [2:0] REG_BG_G      = 3'd3;
  localparam logic [2:0] REG_BG_B      = 3'd4;
  localparam logic [2:0] REG_MAP_BLOCK = 3'd5;
  localparam logic [2:0] REG_FLAGS     = 3'd6;
  localparam logic [2:0] REG_OUTPUT    = 3'd7;

  typedef struct packed {
    logic [2:0]  addr;
    logic [15:0] data;
  } reg_write_t;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } writer_state_t;

endpackage

// File: rtl/vblank_reg_writer_if.sv
// Avalon-MM write-only link between the vblank writer and the sprite peripheral.
interface vblank_reg_writer_if;
  logic [2:0]  avm_address;
  logic [15:0] avm_writedata;
  logic        avm_write;
  logic        avm_chipselect;
  logic        avm_waitrequest;

  modport master (
    output avm_address, avm_writedata, avm_write, avm_chipselect,
    input  avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_writedata, avm_write, avm_chipselect,
    output avm_waitrequest
  );
endinterface

// File: rtl/reg_write_fifo.sv
// Synchronous FIFO of register updates with occupancy count and a one-ahead
// head view so the writer can reload its head copy on the pop edge.
module reg_write_fifo
  import vga_regs_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_push,
  input  reg_write_t       i_wdata,
  input  logic             i_pop,
  output reg_write_t       o_head,
  output reg_write_t       o_head_next,
  output logic [PTR_W:0]   o_count,
  output logic             o_full,
  output logic             o_empty
);

  localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   CNT_ONE = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   CNT_MAX = (PTR_W+1)'(DEPTH);

  reg_write_t       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push_ok;
  logic             w_pop_ok;
  logic [PTR_W-1:0] w_rd_next;

  assign o_full      = (r_count == CNT_MAX);
  assign o_empty     = (r_count == '0);
  assign o_count     = r_count;
  assign w_push_ok   = i_push && !o_full;
  assign w_pop_ok    = i_pop && !o_empty;
  assign w_rd_next   = r_rd_ptr + PTR_ONE;
  assign o_head      = r_mem[r_rd_ptr];
  assign o_head_next = r_mem[w_rd_next];

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop_ok)  r_rd_ptr <= w_rd_next;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/vblank_reg_writer.sv
// Queues sprite register updates and commits a snapshot of them to the
// peripheral only while vertical blanking is active.
//   state | meaning
//   IDLE  | collecting updates, waiting for vblank_start
//   DRAIN | writing the snapshot taken at vblank_start, one entry per accepted beat
module vblank_reg_writer
  import vga_regs_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [2:0]                  in_addr,
  input  logic [15:0]                 in_data,
  input  logic                        vblank_start,
  input  logic                        vblank_active,
  vblank_reg_writer_if.master         avm,
  output logic                        busy,
  output logic                        late,
  input  logic                        clear_late,
  output logic [15:0]                 frame_count
);

  localparam logic [PTR_W:0] SNAP_ONE = {{PTR_W{1'b0}}, 1'b1};

  writer_state_t  r_state, w_state_nxt;
  logic [PTR_W:0] r_snap;
  reg_write_t     r_head;
  logic           r_late;
  logic [15:0]    r_frame_count;

  reg_write_t     w_wdata, w_head, w_head_next;
  logic [PTR_W:0] w_count;
  logic           w_full, w_empty, w_push, w_pop;
  logic           w_load_first, w_load_next, w_frame_inc, w_late_set;

  assign w_wdata  = '{addr: in_addr, data: in_data};
  assign in_ready = !w_full;
  assign w_push   = in_valid && !w_full;

  reg_write_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_push      (w_push),
    .i_wdata     (w_wdata),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_head_next (w_head_next),
    .o_count     (w_count),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_pop        = 1'b0;
    w_load_first = 1'b0;
    w_load_next  = 1'b0;
    w_frame_inc  = 1'b0;
    w_late_set   = 1'b0;
    case (r_state)
      IDLE: begin
        if (vblank_start) begin
          if (!w_empty) begin
            w_state_nxt  = DRAIN;
            w_load_first = 1'b1;
          end else begin
            w_frame_inc  = 1'b1;
          end
        end
      end
      DRAIN: begin
        // Blanking is only sampled at completion, so a stalled beat always finishes.
        if (!avm.avm_waitrequest) begin
          w_pop = 1'b1;
          if (r_snap == SNAP_ONE) begin
            w_state_nxt = IDLE;
            w_frame_inc = 1'b1;
          end else if (!vblank_active) begin
            w_state_nxt = IDLE;
            w_late_set  = 1'b1;
          end else begin
            w_load_next = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_snap        <= '0;
      r_head        <= '0;
      r_late        <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load_first) begin
        r_snap <= w_count;
        r_head <= w_head;
      end else if (w_load_next) begin
        r_snap <= r_snap - SNAP_ONE;
        r_head <= w_head_next;
      end
      if (w_late_set)      r_late <= 1'b1;
      else if (clear_late) r_late <= 1'b0;
      if (w_frame_inc) r_frame_count <= r_frame_count + 16'd1;
    end
  end

  assign avm.avm_write      = (r_state == DRAIN);
  assign avm.avm_chipselect = (r_state == DRAIN);
  assign avm.avm_address    = r_head.addr;
  assign avm.avm_writedata  = r_head.data;
  assign busy               = (r_state == DRAIN);
  assign late               = r_late;
  assign frame_count        = r_frame_count;

endmodule

// File: tb/tb_vblank_reg_writer.sv
// Directed bench for vblank_reg_writer: a per-cycle vector table for the basic
// commit and wait-state cases, then hand sequences for fill, late and reset.
module tb_vblank_reg_writer;
  import vga_regs_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready;
  logic [2:0]  in_addr;
  logic [15:0] in_data;
  logic        vblank_start, vblank_active;
  logic        busy, late, clear_late;
  logic [15:0] frame_count;

  vblank_reg_writer_if bus();

  vblank_reg_writer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_addr       (in_addr),
    .in_data       (in_data),
    .vblank_start  (vblank_start),
    .vblank_active (vblank_active),
    .avm           (bus),
    .busy          (busy),
    .late          (late),
    .clear_late    (clear_late),
    .frame_count   (frame_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [2:0]  a;
    logic [15:0] d;
    logic        vs;
    logic        va;
    logic        wr;
    logic        e_wr;
    logic [2:0]  e_a;
    logic [15:0] e_d;
    logic        e_busy;
    logic [15:0] e_fc;
  } vec_t;

  localparam int NV = 17;
  vec_t        vt [NV];
  logic [18:0] cap [$];
  int          total = 0;
  int          bad   = 0;
  logic [15:0] exp_fc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [2:0] a, input logic [15:0] d);
    in_valid = 1'b1; in_addr = a; in_data = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input bit do_push, input logic [2:0] pa, input logic [15:0] pd,
                           output int n);
    n = 0;
    cap.delete();
    vblank_start = 1'b1; vblank_active = 1'b1;
    @(posedge clk); #1;
    vblank_start = 1'b0;
    if (do_push) begin
      in_valid = 1'b1; in_addr = pa; in_data = pd;
    end
    for (int c = 0; c < 64; c++) begin
      if (!busy) break;
      if (bus.avm_write) begin
        cap.push_back({bus.avm_address, bus.avm_writedata});
        n++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    vblank_active = 1'b0;
    chk("frame_ends", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [18:0] ew;

    vt[0]  = '{1'b1,3'd0,16'h0120,1'b0,1'b0,1'b0, 1'b0,3'd0,16'h0000,1'b0,16'd0};
    vt[1]  = '{1'b1,3'd1,16'h0007,1'b0,1'b0,1'b0, 1'b0,3'd0,16'h0000,1'b0,16'd0};
    vt[2]  = '{1'b1,3'd5,16'h002A,1'b0,1'b0,1'b0, 1'b0,3'd0,16'h0000,1'b0,16'd0};
    vt[3]  = '{1'b0,3'd0,16'h0000,1'b1,1'b1,1'b0, 1'b1,3'd0,16'h0120,1'b1,16'd0};
    vt[4]  = '{1'b0,3'd0,16'h0000,1'b0,1'b1,1'b0, 1'b1,3'd1,16'h0007,1'b1,16'd0};
    vt[5]  = '{1'b0,3'd0,16'h0000,1'b0,1'b1,1'b0, 1'b1,3'd5,16'h002A,1'b1,16'd0};
    vt[6]  = '{1'b0,3'd0,16'h0000,1'b0,1'b1,1'b0, 1'b0,3'd0,16'h0000,1'b0,16'd1};
    vt[7]  = '{1'b1,3'd0,16'h0120,1'b0,1'b0,1'b0, 1'b0,3'd0,16'h0000,1'b0,16'd1};
    vt[8]  = '{1'b1,3'd1,16'h0007,1'b0,1'b0,1'b0, 1'b0,3'd0,16'h0000,1'b0,16'd1};
    vt[9]  = '{1'b1,3'd5,16'h002A,1'b0,1'b0,1'b0, 1'b0,3'd0,16'h0000,1'b0,16'd1};
    vt[10] = '{1'b0,3'd0,16'h0000,1'b1,1'b1,1'b0, 1'b1,3'd0,16'h0120,1'b1,16'd1};
    vt[11] = '{1'b0,3'd0,16'h0000,1'b0,1'b1,1'b0, 1'b1,3'd1,16'h0007,1'b1,16'd1};
    vt[12] = '{1'b0,3'd0,16'h0000,1'b0,1'b1,1'b1, 1'b1,3'd1,16'h0007,1'b1,16'd1};
    vt[13] = '{1'b0,3'd0,16'h0000,1'b0,1'b1,1'b1, 1'b1,3'd1,16'h0007,1'b1,16'd1};
    vt[14] = '{1'b0,3'd0,16'h0000,1'b0,1'b1,1'b0, 1'b1,3'd5,16'h002A,1'b1,16'd1};
    vt[15] = '{1'b0,3'd0,16'h0000,1'b0,1'b1,1'b0, 1'b0,3'd0,16'h0000,1'b0,16'd2};
    vt[16] = '{1'b0,3'd0,16'h0000,1'b1,1'b1,1'b0, 1'b0,3'd0,16'h0000,1'b0,16'd3};

    reset_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;
    vblank_start = 1'b0; vblank_active = 1'b0; clear_late = 1'b0;
    bus.avm_waitrequest = 1'b0;
    #12;
    chk("rst_write",  32'(bus.avm_write), 32'd0);
    chk("rst_cs",     32'(bus.avm_chipselect), 32'd0);
    chk("rst_addr",   32'(bus.avm_address), 32'd0);
    chk("rst_data",   32'(bus.avm_writedata), 32'd0);
    chk("rst_busy",   32'(busy), 32'd0);
    chk("rst_late",   32'(late), 32'd0);
    chk("rst_fc",     32'(frame_count), 32'd0);
    chk("rst_ready",  32'(in_ready), 32'd1);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;

    // basic commit and wait-state vectors
    for (int i = 0; i < NV; i++) begin
      in_valid = vt[i].vld; in_addr = vt[i].a; in_data = vt[i].d;
      vblank_start = vt[i].vs; vblank_active = vt[i].va; bus.avm_waitrequest = vt[i].wr;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_write", i), 32'(bus.avm_write), 32'(vt[i].e_wr));
      chk($sformatf("vec%0d_cs", i), 32'(bus.avm_chipselect), 32'(vt[i].e_wr));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].e_busy));
      chk($sformatf("vec%0d_fc", i), 32'(frame_count), 32'(vt[i].e_fc));
      chk($sformatf("vec%0d_ready", i), 32'(in_ready), 32'd1);
      if (vt[i].e_wr) begin
        chk($sformatf("vec%0d_addr", i), 32'(bus.avm_address), 32'(vt[i].e_a));
        chk($sformatf("vec%0d_data", i), 32'(bus.avm_writedata), 32'(vt[i].e_d));
      end
    end
    in_valid = 1'b0; vblank_start = 1'b0; vblank_active = 1'b0; bus.avm_waitrequest = 1'b0;
    exp_fc = 16'd3;

    // fill to full, stall a 17th push, then commit
    for (int i = 0; i < 16; i++) push(3'(i), 16'h0100 + 16'(i));
    chk("full_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1; in_addr = 3'd6; in_data = 16'hBEEF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("stall_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    run_frame(1'b0, 3'd0, 16'h0, n);
    chk("full_n", 32'(n), 32'd16);
    for (int i = 0; i < 16 && i < n; i++) begin
      ew = {3'(i), 16'h0100 + 16'(i)};
      chk($sformatf("full_w%0d", i), 32'(cap[i]), 32'(ew));
    end
    exp_fc++;
    chk("full_fc", 32'(frame_count), 32'(exp_fc));
    chk("after_ready", 32'(in_ready), 32'd1);
    push(3'd6, 16'hBEEF);
    run_frame(1'b0, 3'd0, 16'h0, n);
    chk("late17_n", 32'(n), 32'd1);
    if (n > 0) chk("late17_w", 32'(cap[0]), 32'({3'd6, 16'hBEEF}));
    exp_fc++;
    chk("late17_fc", 32'(frame_count), 32'(exp_fc));

    // push during drain stays for next frame
    for (int i = 0; i < 4; i++) push(3'(i), 16'h0010 + 16'(i));
    run_frame(1'b1, 3'd2, 16'h00FF, n);
    chk("dpush_n", 32'(n), 32'd4);
    for (int i = 0; i < 4 && i < n; i++) begin
      ew = {3'(i), 16'h0010 + 16'(i)};
      chk($sformatf("dpush_w%0d", i), 32'(cap[i]), 32'(ew));
    end
    exp_fc++;
    chk("dpush_fc", 32'(frame_count), 32'(exp_fc));
    run_frame(1'b0, 3'd0, 16'h0, n);
    chk("dpush_next_n", 32'(n), 32'd1);
    if (n > 0) chk("dpush_next_w", 32'(cap[0]), 32'({3'd2, 16'h00FF}));
    exp_fc++;
    chk("dpush_next_fc", 32'(frame_count), 32'(exp_fc));

    // blanking ends under waitrequest
    for (int i = 0; i < 6; i++) push(3'(i), 16'h00A0 + 16'(i));
    bus.avm_waitrequest = 1'b1;
    vblank_start = 1'b1; vblank_active = 1'b1;
    @(posedge clk); #1;
    vblank_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("hold_write", 32'(bus.avm_write), 32'd1);
      chk("hold_addr", 32'(bus.avm_address), 32'd0);
      chk("hold_data", 32'(bus.avm_writedata), 32'h00A0);
      @(posedge clk); #1;
    end
    vblank_active = 1'b0;
    @(posedge clk); #1;
    chk("lowva_write", 32'(bus.avm_write), 32'd1);
    chk("lowva_addr", 32'(bus.avm_address), 32'd0);
    bus.avm_waitrequest = 1'b0; clear_late = 1'b1;
    @(posedge clk); #1;
    clear_late = 1'b0;
    chk("late_write", 32'(bus.avm_write), 32'd0);
    chk("late_busy", 32'(busy), 32'd0);
    chk("late_set_wins", 32'(late), 32'd1);
    chk("late_fc", 32'(frame_count), 32'(exp_fc));
    clear_late = 1'b1;
    @(posedge clk); #1;
    clear_late = 1'b0;
    chk("late_clear", 32'(late), 32'd0);
    run_frame(1'b0, 3'd0, 16'h0, n);
    chk("rest_n", 32'(n), 32'd5);
    for (int i = 0; i < 5 && i < n; i++) begin
      ew = {3'(i + 1), 16'h00A1 + 16'(i)};
      chk($sformatf("rest_w%0d", i), 32'(cap[i]), 32'(ew));
    end
    exp_fc++;
    chk("rest_fc", 32'(frame_count), 32'(exp_fc));

    // reset mid-drain
    for (int i = 0; i < 3; i++) push(3'(i + 4), 16'h0300 + 16'(i));
    vblank_start = 1'b1; vblank_active = 1'b1;
    @(posedge clk); #1;
    vblank_start = 1'b0;
    chk("pre_rst_write", 32'(bus.avm_write), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_write", 32'(bus.avm_write), 32'd0);
    chk("mid_rst_cs", 32'(bus.avm_chipselect), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_fc", 32'(frame_count), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_late", 32'(late), 32'd0);
    vblank_active = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    run_frame(1'b0, 3'd0, 16'h0, n);
    chk("post_rst_n", 32'(n), 32'd0);
    chk("post_rst_fc", 32'(frame_count), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vblank_reg_writer.md
Name: vblank_reg_writer

Overview:
- Avalon-MM write initiator that feeds the VGA sprite peripheral's 8-entry, 16-bit register port.
- Game logic pushes (address, data) register updates into an internal FIFO at any time.
- The block commits queued updates to the peripheral only during vertical blanking. This keeps player_y_pos, x_shift and map_block changes free of tearing.
- It sits between the game-logic/HPS bridge and the peripheral's slave port.

Parameters:
- DEPTH, 16, FIFO entries (power of two, ≥2)
- PTR_W, $clog2(DEPTH), FIFO pointer width

Ports:
- clk  in  1  system clock (50 MHz)
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  update request valid
- in_ready  out  1  FIFO can accept (= !full)
- in_addr  in  3  target register index 0..7
- in_data  in  16  target register value
- vblank_start  in  1  one-cycle pulse at first line of vertical blanking
- vblank_active  in  1  high throughout vertical blanking
- avm_address  out  3  register index to peripheral
- avm_writedata  out  16  register value
- avm_write  out  1  write strobe
- avm_chipselect  out  1  select; identical to avm_write
- avm_waitrequest  in  1  peripheral stall
- busy  out  1  high in DRAIN
- late  out  1  sticky: blanking ended with committed entries unsent
- clear_late  in  1  synchronous clear of late
- frame_count  out  16  number of completed commits, wraps at 0xFFFF→0

Behaviour:
- Reset (async assert, sync-released use): pointers=0, count=0, state=IDLE.
  - Outputs at reset: avm_write=0, avm_chipselect=0, avm_address=0, avm_writedata=0, busy=0, late=0, frame_count=0, in_ready=1.
- FIFO push:
  - Entry written on in_valid && in_ready.
  - Push and pop in the same cycle are both allowed; count stays unchanged.
  - Full means count==DEPTH; in_ready=0.
  - Pointers wrap modulo DEPTH; count is PTR_W+1 bits.
- States: IDLE, DRAIN.
- IDLE → DRAIN on vblank_start when count>0.
  - snap (PTR_W+1 bits) is loaded with the current count in that cycle. A push in the same cycle is not included.
- IDLE with vblank_start and count==0:
  - Stays in IDLE.
  - frame_count still increments (empty commit).
- DRAIN:
  - avm_write=avm_chipselect=1.
  - avm_address/avm_writedata come from a registered copy of the FIFO head.
  - Transfer completes on a cycle with avm_write=1 && avm_waitrequest=0. On that edge: pop, snap decrements, next head is loaded.
  - Back-to-back transfers happen at one per cycle with zero wait states.
  - While avm_waitrequest=1, address, data and write are held stable.
- DRAIN → IDLE when a transfer completes with snap==1.
  - avm_write deasserts the following cycle.
  - frame_count increments.
- Entries pushed during DRAIN remain for the next frame.
- Early end of blanking:
  - If vblank_active is low at a completion edge and snap>1, finish that transfer and go to IDLE.
  - Set late=1; do not increment frame_count.
  - Never abort a transfer mid-waitrequest.
- vblank_start while in DRAIN is ignored.
- clear_late and a late-set in the same cycle: set wins.
- Reset mid-DRAIN: avm_write drops immediately (async) and FIFO contents are discarded.
- Latency: first avm_write is asserted the cycle after vblank_start.

Decomposition:
- Shared package vga_regs_pkg:
  - Register index constants: REG_PLAYER_Y=0, REG_X_SHIFT=1, REG_BG_R=2, REG_BG_G=3, REG_BG_B=4, REG_MAP_BLOCK=5, REG_FLAGS=6, REG_OUTPUT=7.
  - typedef struct reg_write_t {logic [2:0] addr; logic [15:0] data;}.
  - typedef enum writer_state_t {IDLE, DRAIN}.
- One sub-module: reg_write_fifo (synchronous FIFO of reg_write_t with count, full, empty, simultaneous push/pop).

Test Plan:
- Push (0,0x0120),(1,0x0007),(5,0x002A), then pulse vblank_start, vblank_active=1, waitrequest=0 → three consecutive avm_write cycles with those address/data pairs starting the next cycle; frame_count=1; busy low after.
- Same three entries with waitrequest high for 2 cycles on the second transfer → second address/data held for 3 cycles; total 5 write cycles; order preserved.
- Fill 16 entries → in_ready=0; a 17th push is stalled, not lost. After commit, in_ready=1 and the 17th is accepted.
- Push 4, vblank_start, push (2,0x00FF) during DRAIN → only 4 writes this frame; the fifth goes out on the next vblank_start; frame_count=2.
- 6 entries, waitrequest=1 throughout, vblank_active drops after 3 cycles → the first transfer completes once waitrequest is released, then IDLE; late=1; 5 entries remain; frame_count unchanged.
- Assert reset_n=0 mid-DRAIN → avm_write=0 in the same cycle; after release, count=0, in_ready=1, late=0, frame_count=0.
